// File: rtl/seg_pkg.sv
// Shared segment-code types and the BCD to 7-segment decode function used by
// the scan controller (segment order A..G, MSB..LSB, active-high).
package seg_pkg;

    typedef logic [6:0] seg_code_t;

    localparam seg_code_t SEG_BLANK = 7'b0000000;
    localparam seg_code_t SEG_0     = 7'b1111110;
    localparam seg_code_t SEG_1     = 7'b0110000;
    localparam seg_code_t SEG_2     = 7'b1101101;
    localparam seg_code_t SEG_3     = 7'b1111001;
    localparam seg_code_t SEG_4     = 7'b0110011;
    localparam seg_code_t SEG_5     = 7'b1011011;
    localparam seg_code_t SEG_6     = 7'b1011111;
    localparam seg_code_t SEG_7     = 7'b1110000;
    localparam seg_code_t SEG_8     = 7'b1111111;
    localparam seg_code_t SEG_9     = 7'b1110011;

    // Non-BCD codes (10..15) render dark; the caller still drives the anode.
    function automatic seg_code_t seg_decode(input logic [3:0] bcd);
        seg_code_t code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of control inputs and display outputs of the segment scan controller.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import seg_pkg::*;

    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    seg_code_t                 seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;
    logic                      pending;

    modport master (
        output en, load, digits,
        input  seg, an, frame_done, pending
    );

    modport slave (
        input  en, load, digits,
        output seg, an, frame_done, pending
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot prescaler: counts 0..SCAN_DIV-1 while enabled, tick on the terminal count.
module seg_scan_timer #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Combinational so the index advances on the same edge the count wraps.
    assign tick = en && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with shadow/active double buffering.
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_ctrl_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                    tick;
    logic                    wrap;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] active_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic                    pending_reg;
    seg_code_t               seg_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    frame_done_reg;
    logic [3:0]              digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lead_blank;

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .tick  (tick)
    );

    assign wrap = tick && (idx_reg == IDX_LAST);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
        assign digit_arr[gi] = active_reg[4*gi +: 4];
    end

`ifdef SEG_SCAN_LZB_EN
    // A slot is dark when it and every more significant digit are zero; digit 0 always shows.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
        if (gi == 0) begin : g_lsd
            assign lead_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lead_blank[gi] = ~|active_reg[4*NUM_DIGITS-1 : 4*gi];
        end
    end
`else
    assign lead_blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= '0;
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            seg_reg        <= SEG_BLANK;
            an_reg         <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            if (tick) begin
                idx_reg <= wrap ? '0 : idx_reg + 1'b1;
            end
            frame_done_reg <= wrap;

            // A load landing on the boundary edge only refills the shadow; the
            // previously pending value (if any) is what gets committed here.
            if (wrap && pending_reg) begin
                active_reg <= shadow_reg;
            end
            if (bus.load) begin
                shadow_reg  <= bus.digits;
                pending_reg <= 1'b1;
            end else if (wrap) begin
                pending_reg <= 1'b0;
            end

            if (!bus.en || lead_blank[idx_reg]) begin
                seg_reg <= SEG_BLANK;
                an_reg  <= '0;
            end else begin
                seg_reg <= seg_decode(digit_arr[idx_reg]);
                an_reg  <= NUM_DIGITS'(1) << idx_reg;
            end
        end
    end

    assign bus.seg        = seg_reg;
    assign bus.an         = an_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.pending    = pending_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4 (16-clock frame).
module tb_seg_scan_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [6:0] seg4321 [4];
        seg4321[0] = 7'b0110000;
        seg4321[1] = 7'b1101101;
        seg4321[2] = 7'b1111001;
        seg4321[3] = 7'b0110011;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.digits = '0;

        // Reset state
        cyc(); cyc();
        check("rst_seg", bus.seg, 7'b0000000);
        check("rst_an", bus.an, 4'b0000);
        check("rst_fd", bus.frame_done, 1'b0);
        check("rst_pend", bus.pending, 1'b0);

        // Load 0x4321 right after reset release; committed at the first boundary (edge 16)
        rst_n = 1'b1; bus.en = 1'b1; bus.load = 1'b1; bus.digits = 16'h4321;
        cyc();
        bus.load = 1'b0;
        check("e1_pend", bus.pending, 1'b1);
        check("e1_an", bus.an, 4'b0001);
        check("e1_seg_old", bus.seg, 7'b1111110);
        repeat (15) cyc();
        check("e16_fd", bus.frame_done, 1'b1);
        check("e16_pend", bus.pending, 1'b0);
        check("e16_an", bus.an, 4'b1000);
        cyc();
        check("e17_fd", bus.frame_done, 1'b0);
        check("e17_an", bus.an, 4'b0001);
        check("e17_seg", bus.seg, seg4321[0]);
        for (int d = 1; d < 4; d++) begin
            repeat (4) cyc();
            check("f1_an", bus.an, 4'b0001 << d);
            check("f1_seg", bus.seg, seg4321[d]);
        end

        // Mid-frame load of 0x1111 at edge 30, boundary at edge 32
        bus.load = 1'b1; bus.digits = 16'h1111;
        cyc();
        bus.load = 1'b0;
        check("mid_pend", bus.pending, 1'b1);
        check("mid_seg_hold", bus.seg, 7'b0110011);
        check("mid_an_hold", bus.an, 4'b1000);
        repeat (2) cyc();
        check("mid_commit_pend", bus.pending, 1'b0);
        check("mid_commit_fd", bus.frame_done, 1'b1);
        cyc();
        check("ones_an0", bus.an, 4'b0001);
        check("ones_seg0", bus.seg, 7'b0110000);
        for (int d = 1; d < 4; d++) begin
            repeat (4) cyc();
            check("ones_an", bus.an, 4'b0001 << d);
            check("ones_seg", bus.seg, 7'b0110000);
        end

        // Load 0x2468 sampled on the boundary edge 48: old value stays one more frame
        repeat (2) cyc();
        bus.load = 1'b1; bus.digits = 16'h2468;
        cyc();
        bus.load = 1'b0;
        check("bnd_pend", bus.pending, 1'b1);
        check("bnd_fd", bus.frame_done, 1'b1);
        cyc();
        check("bnd_old_seg0", bus.seg, 7'b0110000);
        check("bnd_old_an0", bus.an, 4'b0001);
        repeat (12) cyc();
        check("bnd_old_seg3", bus.seg, 7'b0110000);
        check("bnd_old_an3", bus.an, 4'b1000);
        check("bnd_still_pend", bus.pending, 1'b1);
        repeat (3) cyc();
        check("bnd_commit_pend", bus.pending, 1'b0);
        cyc();
        check("new_seg0", bus.seg, 7'b1111111);
        check("new_an0", bus.an, 4'b0001);

        // en dropped for 10 cycles while slot 2 has counted 0,1
        repeat (8) cyc();
        check("pre_hold_an", bus.an, 4'b0100);
        check("pre_hold_seg", bus.seg, 7'b0110011);
        bus.en = 1'b0;
        cyc();
        check("hold_seg", bus.seg, 7'b0000000);
        check("hold_an", bus.an, 4'b0000);
        for (int i = 0; i < 9; i++) begin
            cyc();
            check("hold_fd", bus.frame_done, 1'b0);
        end
        check("hold_end_seg", bus.seg, 7'b0000000);
        check("hold_end_an", bus.an, 4'b0000);
        bus.en = 1'b1;
        cyc();
        check("resume_an", bus.an, 4'b0100);
        check("resume_seg", bus.seg, 7'b0110011);
        cyc(); cyc();
        check("resume_an_last", bus.an, 4'b0100);
        cyc();
        check("resume_next_an", bus.an, 4'b1000);
        check("resume_next_seg", bus.seg, 7'b1101101);
        repeat (3) cyc();
        check("resume_fd", bus.frame_done, 1'b1);

        // Non-BCD digit and zero digits: 0x00A5
        bus.load = 1'b1; bus.digits = 16'h00A5;
        cyc();
        bus.load = 1'b0;
        check("a5_pend", bus.pending, 1'b1);
        repeat (15) cyc();
        check("a5_commit_pend", bus.pending, 1'b0);
        check("a5_fd", bus.frame_done, 1'b1);
        cyc();
        check("a5_seg0", bus.seg, 7'b1011011);
        check("a5_an0", bus.an, 4'b0001);
        repeat (4) cyc();
        check("a5_seg1", bus.seg, 7'b0000000);
        check("a5_an1", bus.an, 4'b0010);
        repeat (4) cyc();
`ifdef SEG_SCAN_LZB_EN
        check("a5_seg2_lzb", bus.seg, 7'b0000000);
        check("a5_an2_lzb", bus.an, 4'b0000);
`else
        check("a5_seg2", bus.seg, 7'b1111110);
        check("a5_an2", bus.an, 4'b0100);
`endif

        // Asynchronous reset mid-slot while a load is pending
        bus.load = 1'b1; bus.digits = 16'h9999;
        cyc();
        bus.load = 1'b0;
        check("ar_pend_before", bus.pending, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_seg", bus.seg, 7'b0000000);
        check("ar_an", bus.an, 4'b0000);
        check("ar_pend", bus.pending, 1'b0);
        check("ar_fd", bus.frame_done, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        check("ar_rel_an", bus.an, 4'b0001);
        check("ar_rel_seg", bus.seg, 7'b1111110);
        check("ar_rel_pend", bus.pending, 1'b0);
        repeat (16) cyc();
        check("ar_frame2_an", bus.an, 4'b0001);
        check("ar_frame2_seg", bus.seg, 7'b1111110);
        check("ar_frame2_pend", bus.pending, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
